// File: rtl/sap_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : sap_serial_subtractor_if
// Purpose  : Request/response bundle for the bit-serial subtractor.
//            The controller (master) drives start and the operands.
//            The subtractor (slave) returns status and the result.
// Signals  : start      request, sampled only while the subtractor is idle
//            a, b, bin  minuend, subtrahend, borrow-in (captured on accept)
//            busy       high while bits are being shifted
//            done       one-cycle completion pulse
//            d          difference, held until the next completion
//            bout       borrow-out (a < b + bin, unsigned)
//            z          difference is zero
// Revision : 1.0  initial release
// ============================================================================
interface sap_serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             z;

   modport master (
      output start, a, b, bin,
      input  busy, done, d, bout, z
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, d, bout, z
   );
endinterface
`default_nettype wire

// File: rtl/sap_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : sap_serial_subtractor
// Purpose  : Bit-serial subtractor, D = A - B - BIN (mod 2^WIDTH), one bit
//            per clock, LSB first, using a single borrow flip-flop.
// Ports    : clk    rising-edge clock
//            clr_n  asynchronous active-low reset
//            bus    sap_serial_subtractor_if.slave (start/a/b/bin in,
//                   busy/done/d/bout/z out)
// Params   : WIDTH  operand/result width, 2..32
// Revision : 1.0  initial release
// ============================================================================
module sap_serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  wire logic              clk,
   input  wire logic              clr_n,
   sap_serial_subtractor_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] c_count_load = CW'(WIDTH);
   localparam logic [CW-1:0] c_count_last = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FIN   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_acc;
   logic             r_borrow;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;
   logic             r_z;

   logic             w_busy;
   logic             w_done;
   logic             w_accept;
   logic             w_last;
   logic             w_a_bit;
   logic             w_b_bit;
   logic             w_diff_bit;
   logic             w_borrow_nxt;
   logic [WIDTH-1:0] w_acc_nxt;

   // One full-subtractor cell, fed from the LSB of each operand register.
   assign w_a_bit      = r_a_sr[0];
   assign w_b_bit      = r_b_sr[0];
   assign w_diff_bit   = w_a_bit ^ w_b_bit ^ r_borrow;
   assign w_borrow_nxt = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);

   // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
   assign w_acc_nxt    = {w_diff_bit, r_acc[WIDTH-1:1]};

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_busy = 1'b1;
            // The edge that consumes the final bit publishes the result.
            if (r_count == c_count_last) begin
               w_last      = 1'b1;
               w_state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: operand shift registers, borrow, count and published result
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_acc    <= '0;
         r_borrow <= 1'b0;
         r_count  <= '0;
         r_d      <= '0;
         r_bout   <= 1'b0;
         r_z      <= 1'b1;
      end else if (w_accept) begin
         r_a_sr   <= bus.a;
         r_b_sr   <= bus.b;
         r_acc    <= '0;
         r_borrow <= bus.bin;
         r_count  <= c_count_load;
      end else if (w_busy) begin
         r_a_sr   <= r_a_sr >> 1;
         r_b_sr   <= r_b_sr >> 1;
         r_acc    <= w_acc_nxt;
         r_borrow <= w_borrow_nxt;
         r_count  <= r_count - c_count_last;
         // d, bout and z move together and only here, never mid-shift.
         if (w_last) begin
            r_d    <= w_acc_nxt;
            r_bout <= w_borrow_nxt;
            r_z    <= (w_acc_nxt == '0);
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.d    = r_d;
   assign bus.bout = r_bout;
   assign bus.z    = r_z;

endmodule
`default_nettype wire

// File: tb/tb_sap_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap_serial_subtractor
// Purpose  : Directed self-checking bench for sap_serial_subtractor; an
//            8-bit instance for the directed cases and a 4-bit instance for
//            the full operand sweep.
// Revision : 1.0  initial release
// ============================================================================
module tb_sap_serial_subtractor;

   logic clk;
   logic clr_n;

   sap_serial_subtractor_if #(.WIDTH(8)) bus8 ();
   sap_serial_subtractor_if #(.WIDTH(4)) bus4 ();

   sap_serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus8.slave)
   );

   sap_serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] r_prev_d = 8'h00;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation. mid_start >= 1 raises an extra START on that busy
   // cycle; fin_start raises START during the DONE cycle.
   task automatic run_op8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                          input logic bin_v, input logic [7:0] exp_d, input logic exp_bout,
                          input logic exp_z, input int mid_start, input bit fin_start);
      int n;
      @(negedge clk);
      bus8.a     = a_v;
      bus8.b     = b_v;
      bus8.bin   = bin_v;
      bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a     = ~a_v;
      bus8.b     = ~b_v;
      bus8.bin   = ~bin_v;
      n = 0;
      while (bus8.busy && n < 20) begin
         n++;
         check_value({tag, "_d_hold"}, 32'(bus8.d), 32'(r_prev_d));
         if (n == mid_start) begin
            bus8.start = 1'b1;
            bus8.a     = 8'h01;
            bus8.b     = 8'h02;
         end else begin
            bus8.start = 1'b0;
         end
         @(negedge clk);
      end
      bus8.start = 1'b0;
      check_value({tag, "_busy_cycles"}, 32'(n), 32'd8);
      check_value({tag, "_done"}, 32'(bus8.done), 32'd1);
      check_value({tag, "_d"}, 32'(bus8.d), 32'(exp_d));
      check_value({tag, "_bout"}, 32'(bus8.bout), 32'(exp_bout));
      check_value({tag, "_z"}, 32'(bus8.z), 32'(exp_z));
      r_prev_d = exp_d;
      if (fin_start) begin
         bus8.start = 1'b1;
         bus8.a     = 8'h00;
         bus8.b     = 8'h01;
         @(negedge clk);
         bus8.start = 1'b0;
         check_value({tag, "_fin_start_busy"}, 32'(bus8.busy), 32'd0);
         check_value({tag, "_fin_start_done"}, 32'(bus8.done), 32'd0);
         @(negedge clk);
         check_value({tag, "_fin_start_not_queued"}, 32'(bus8.busy), 32'd0);
         check_value({tag, "_fin_start_d"}, 32'(bus8.d), 32'(exp_d));
      end else begin
         @(negedge clk);
         check_value({tag, "_done_drop"}, 32'(bus8.done), 32'd0);
      end
   endtask

   initial begin
      int n;
      int n_done;

      clr_n      = 1'b0;
      bus8.start = 1'b0;
      bus8.a     = '0;
      bus8.b     = '0;
      bus8.bin   = 1'b0;
      bus4.start = 1'b0;
      bus4.a     = '0;
      bus4.b     = '0;
      bus4.bin   = 1'b0;

      repeat (2) @(negedge clk);
      check_value("rst_busy", 32'(bus8.busy), 32'd0);
      check_value("rst_done", 32'(bus8.done), 32'd0);
      check_value("rst_d",    32'(bus8.d),    32'd0);
      check_value("rst_bout", 32'(bus8.bout), 32'd0);
      check_value("rst_z",    32'(bus8.z),    32'd1);
      check_value("rst_z4",   32'(bus4.z),    32'd1);
      clr_n = 1'b1;
      @(negedge clk);
      check_value("idle_busy", 32'(bus8.busy), 32'd0);

      run_op8("t1",     8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, -1, 1'b0);
      run_op8("t2a",    8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, -1, 1'b0);
      run_op8("t2b",    8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, -1, 1'b0);
      run_op8("t3",     8'h7F, 8'h7E, 1'b1, 8'h00, 1'b0, 1'b1, -1, 1'b0);
      run_op8("t4",     8'hC3, 8'h41, 1'b0, 8'h82, 1'b0, 1'b0,  3, 1'b1);

      // Reset in the fourth SHIFT cycle aborts the operation.
      @(negedge clk);
      bus8.a     = 8'h99;
      bus8.b     = 8'h11;
      bus8.bin   = 1'b0;
      bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      check_value("t5_busy_before", 32'(bus8.busy), 32'd1);
      clr_n = 1'b0;
      #1;
      check_value("t5_rst_busy", 32'(bus8.busy), 32'd0);
      check_value("t5_rst_done", 32'(bus8.done), 32'd0);
      check_value("t5_rst_d",    32'(bus8.d),    32'd0);
      check_value("t5_rst_bout", 32'(bus8.bout), 32'd0);
      check_value("t5_rst_z",    32'(bus8.z),    32'd1);
      @(negedge clk);
      clr_n    = 1'b1;
      r_prev_d = 8'h00;
      n_done   = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus8.done || bus8.busy) n_done++;
      end
      check_value("t5_no_done", 32'(n_done), 32'd0);
      check_value("t5_d_after", 32'(bus8.d), 32'd0);
      run_op8("t5_fresh", 8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0, -1, 1'b0);

      // Exhaustive 4-bit sweep against plain integer arithmetic.
      for (int v = 0; v < 512; v++) begin
         int av;
         int bv;
         int cv;
         int exp_res;
         av      = v & 15;
         bv      = (v >> 4) & 15;
         cv      = (v >> 8) & 1;
         exp_res = (av - bv - cv) & 31;
         @(negedge clk);
         bus4.a     = 4'(av);
         bus4.b     = 4'(bv);
         bus4.bin   = 1'(cv);
         bus4.start = 1'b1;
         @(negedge clk);
         bus4.start = 1'b0;
         n = 0;
         while (bus4.busy && n < 10) begin
            n++;
            @(negedge clk);
         end
         check_value($sformatf("sweep_lat_%0d", v), 32'(n), 32'd4);
         check_value($sformatf("sweep_done_%0d", v), 32'(bus4.done), 32'd1);
         check_value($sformatf("sweep_res_%0d", v), 32'({bus4.bout, bus4.d}), 32'(exp_res));
         check_value($sformatf("sweep_z_%0d", v), 32'(bus4.z), 32'((exp_res & 15) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
